bayer_mosaic_gen: RTL and testbench
===================================

// Module: bayer_mosaic_gen
// PURPOSE
//  RGB-to-Bayer re-mosaic. Inverse of the CFA demosaic stage: takes 8-bit RGB video with vsync/hsync/den and
//  emits one 8-bit raw sample per pixel, chosen by pixel parity and a selectable Bayer phase.
//  Sits at the front of the ISP test path so synthetic RGB frames can drive the raw pipeline.
//  Also checks frame geometry and reports sticky size errors.
// PARAMETERS
//  source_h       512  active pixels (den cycles) per line expected
//  source_v       512  active lines per frame expected
//  BAYER_PATTERN  0    Bayer phase: 0=RGGB 1=GRBG 2=GBRG 3=BGGR (values from isp_defines.vh)
// PORTS
//  clk        in   1   pixel clock
//  reset_n    in   1   reset, synchronous, active-low
//  in_vsync   in   1   high for the whole frame
//  in_hsync   in   1   high for the whole line
//  in_den     in   1   pixel valid
//  in_R       in   8   red
//  in_G       in   8   green
//  in_B       in   8   blue
//  err_clr    in   1   1-cycle pulse: clear sticky errors
//  out_vsync  out  1   in_vsync delayed 2 cycles
//  out_hsync  out  1   in_hsync delayed 2 cycles
//  out_den    out  1   in_den delayed 2 cycles, gated by sync state
//  out_raw    out  8   mosaiced sample; 0 when out_den=0
//  frame_done out  1   1-cycle pulse coincident with the falling edge of out_vsync
//  frame_cnt  out  16  completed frames, wraps 65535->0
//  err_hlen   out  1   sticky: a line had den count != source_h
//  err_vlen   out  1   sticky: a frame had line count != source_v
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): all outputs 0, counters 0, FSM=UNSYNC, pipeline flushed.
//  FSM: UNSYNC --in_vsync=0--> VBLANK --in_vsync=1--> FRAME --in_vsync=0--> VBLANK.
//   UNSYNC: syncs pass through the pipe, out_den=0, out_raw=0, no checks, no frame_done.
//   Mid-frame reset therefore drops the rest of the current frame; the next full frame is processed.
//  Position: x = den count since in_hsync rose (0-based); y = lines completed since in_vsync rose.
//   x clears while in_hsync=0. y clears in VBLANK. y increments on in_hsync falling edge only if the line had >=1 den.
//   x and y are 12-bit and saturate at 4095; no wrap.
//  Selection, p={y[0],x[0]}. RGGB: 00=R 01=G 10=G 11=B. GRBG: 00=G 01=R 10=B 11=G.
//   GBRG: 00=G 01=B 10=R 11=G. BGGR: 00=B 01=G 10=G 11=R.
//  Pipeline: stage1 registers syncs, RGB and p; stage2 selects into out_raw. Latency is exactly 2 clk for every output.
//  Line check, in FRAME: on in_hsync falling, if the line's den count != source_h then set err_hlen.
//   Lines with zero den are ignored.
//  Frame check: on FRAME->VBLANK, if y != source_v then set err_vlen; frame_cnt++; frame_done fires 2 cycles later.
//  err_clr: clears both flags next cycle. A new error in the same cycle as err_clr wins, so the flag stays 1.
//  Sync edges are detected against the stage1 copies (1-cycle registered edge detect).
//  Frame boundary and line-end in the same cycle: the line check runs first, then y is tested including that line.
// STRUCTURE
//  isp_defines.vh: BAYER_RGGB/GRBG/GBRG/BGGR localparams and FSM state encodings (UNSYNC=2'd0, VBLANK=2'd1, FRAME=2'd2).
//  Sub-module frame_geom_check: x/y counters, edge detect, err_hlen/err_vlen/frame_cnt. It is reusable by other ISP stages.
//  Top: FSM, 2-stage data/sync pipe, pattern select mux.
// TESTING (bench uses source_h=4, source_v=4)
//  1 RGGB, after one vblank, 4x4 frame with R=8'h10 G=8'h20 B=8'h30 -> out_raw row0 = 10,20,10,20; row1 = 20,30,20,30. 2-cycle lag vs in_den.
//  2 BAYER_PATTERN=3, same frame -> row0 = 30,20,30,20; row1 = 20,10,20,10.
//  3 Line 2 has 3 den -> err_hlen=1 from the 2nd cycle after that in_hsync fall. err_clr -> 0. Next good frame keeps it 0.
//  4 Frame with 5 lines -> err_vlen=1 and frame_done=1 exactly 2 cycles after in_vsync falls. frame_cnt increments by 1.
//  5 Reset mid-line 1, then resume -> out_den=0 until in_vsync=0 is seen. Following frame matches test 1. No errors set.
//  6 err_clr pulsed in the same cycle a short line ends -> err_hlen remains 1.

Source files
------------

// File: rtl/bayer_mosaic_gen_pkg.sv
// Shared definitions for the RGB-to-Bayer re-mosaic block: Bayer phase codes,
// sync FSM encodings, position counter width and the CFA sample selector.
package bayer_mosaic_gen_pkg;

  localparam int unsigned BAYER_RGGB = 0;
  localparam int unsigned BAYER_GRBG = 1;
  localparam int unsigned BAYER_GBRG = 2;
  localparam int unsigned BAYER_BGGR = 3;

  localparam int unsigned POS_W = 12;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  typedef enum logic [1:0] {
    StUnsync = 2'd0,
    StVblank = 2'd1,
    StFrame  = 2'd2
  } sync_state_e;

  // Every phase is RGGB with the tile origin shifted by one pixel in x and/or y.
  function automatic logic [7:0] bayer_pick(input logic [1:0] pattern, input logic [1:0] p,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    logic [1:0] q;
    case (pattern)
      2'(BAYER_GRBG): q = p ^ 2'b01;
      2'(BAYER_GBRG): q = p ^ 2'b10;
      2'(BAYER_BGGR): q = p ^ 2'b11;
      default:        q = p;
    endcase
    case (q)
      2'b00:   return r;
      2'b11:   return b;
      default: return g;
    endcase
  endfunction

endpackage

// File: rtl/frame_geom_check.sv
// Pixel/line position counters plus sticky line-length and frame-height checks.
// Hits are detected on the input side and published one cycle later, aligned with a 2-stage pipe.
module frame_geom_check #(
  parameter int unsigned source_h = 512,
  parameter int unsigned source_v = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        den,
  input  logic        check_en,
  input  logic        clear_y,
  input  logic        frame_end,
  input  logic        err_clr,
  output logic [1:0]  pos_p,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic [15:0] frame_cnt,
  output logic        frame_done
);
  import bayer_mosaic_gen_pkg::*;

  localparam logic [POS_W-1:0] SrcH = POS_W'(source_h);
  localparam logic [POS_W-1:0] SrcV = POS_W'(source_v);

  logic             hsync_q;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d, y_inc, y_eff;
  logic             hs_fall, line_end, hlen_hit_d, vlen_hit_d;
  logic             hlen_hit_q, vlen_hit_q, fend_q;
  logic             err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d;
  logic [15:0]      frame_cnt_q;
  logic             frame_done_q;

  always_comb begin
    hs_fall  = hsync_q & ~hsync;
    line_end = hs_fall & (x_q != '0);
    y_inc    = (y_q == POS_MAX) ? y_q : y_q + 1'b1;
    // A line ending on the frame boundary is counted before the height test.
    y_eff      = line_end ? y_inc : y_q;
    hlen_hit_d = check_en & line_end & (x_q != SrcH);
    vlen_hit_d = frame_end & (y_eff != SrcV);

    x_d = x_q;
    if (!hsync) begin
      x_d = '0;
    end else if (den && (x_q != POS_MAX)) begin
      x_d = x_q + 1'b1;
    end
    y_d = y_q;
    if (clear_y) begin
      y_d = '0;
    end else if (line_end) begin
      y_d = y_inc;
    end

    // An error detected on the same edge as err_clr keeps the flag set.
    err_hlen_d = hlen_hit_q | (err_hlen_q & ~(err_clr & ~hlen_hit_d));
    err_vlen_d = vlen_hit_q | (err_vlen_q & ~(err_clr & ~vlen_hit_d));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hsync_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      hlen_hit_q   <= 1'b0;
      vlen_hit_q   <= 1'b0;
      fend_q       <= 1'b0;
      err_hlen_q   <= 1'b0;
      err_vlen_q   <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hsync_q      <= hsync;
      x_q          <= x_d;
      y_q          <= y_d;
      hlen_hit_q   <= hlen_hit_d;
      vlen_hit_q   <= vlen_hit_d;
      fend_q       <= frame_end;
      err_hlen_q   <= err_hlen_d;
      err_vlen_q   <= err_vlen_d;
      frame_cnt_q  <= fend_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
      frame_done_q <= fend_q;
    end
  end

  assign pos_p      = {y_q[0], x_q[0]};
  assign err_hlen   = err_hlen_q;
  assign err_vlen   = err_vlen_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/bayer_mosaic_gen.sv
// RGB-to-Bayer re-mosaic: sync FSM, 2-stage sync/data pipe and CFA sample select,
// with frame geometry checking delegated to frame_geom_check.
module bayer_mosaic_gen #(
  parameter int unsigned source_h      = 512,
  parameter int unsigned source_v      = 512,
  parameter int unsigned BAYER_PATTERN = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  input  logic [7:0]  in_R,
  input  logic [7:0]  in_G,
  input  logic [7:0]  in_B,
  input  logic        err_clr,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic [7:0]  out_raw,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_hlen,
  output logic        err_vlen
);
  import bayer_mosaic_gen_pkg::*;

  localparam logic [1:0] Pattern = 2'(BAYER_PATTERN);

  sync_state_e state_q, state_d;
  logic        sync_ok, check_en, clear_y, frame_end;
  logic [1:0]  pos_p;
  logic        s1_vsync, s1_hsync, s1_den;
  logic [7:0]  s1_r, s1_g, s1_b;
  logic [1:0]  s1_p;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StUnsync;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUnsync: if (!in_vsync) state_d = StVblank;
      StVblank: if (in_vsync)  state_d = StFrame;
      StFrame:  if (!in_vsync) state_d = StVblank;
      default:  state_d = StUnsync;
    endcase
  end

  always_comb begin
    sync_ok   = (state_q != StUnsync);
    check_en  = (state_q == StFrame);
    clear_y   = (state_q != StFrame);
    frame_end = check_en & ~in_vsync;
  end

  frame_geom_check #(
    .source_h(source_h),
    .source_v(source_v)
  ) u_geom (
    .clk       (clk),
    .reset_n   (reset_n),
    .hsync     (in_hsync),
    .den       (in_den & sync_ok),
    .check_en  (check_en),
    .clear_y   (clear_y),
    .frame_end (frame_end),
    .err_clr   (err_clr),
    .pos_p     (pos_p),
    .err_hlen  (err_hlen),
    .err_vlen  (err_vlen),
    .frame_cnt (frame_cnt),
    .frame_done(frame_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vsync  <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_den    <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_p      <= '0;
      out_vsync <= 1'b0;
      out_hsync <= 1'b0;
      out_den   <= 1'b0;
      out_raw   <= '0;
    end else begin
      s1_vsync  <= in_vsync;
      s1_hsync  <= in_hsync;
      s1_den    <= in_den & sync_ok;
      s1_r      <= in_R;
      s1_g      <= in_G;
      s1_b      <= in_B;
      s1_p      <= pos_p;
      out_vsync <= s1_vsync;
      out_hsync <= s1_hsync;
      out_den   <= s1_den;
      out_raw   <= s1_den ? bayer_pick(Pattern, s1_p, s1_r, s1_g, s1_b) : 8'h00;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_gen.sv
// Scoreboard bench for bayer_mosaic_gen: RGGB and BGGR instances share stimulus; pixel and
// flag expectations are queued at issue time and checked by negedge monitors.
module tb_bayer_mosaic_gen;

  localparam int SrcH = 4;
  localparam int SrcV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_vsync = 1'b1, in_hsync = 1'b0, in_den = 1'b0, err_clr = 1'b0;
  logic [7:0] in_R = 8'h10, in_G = 8'h20, in_B = 8'h30;

  logic o0_vsync, o0_hsync, o0_den, o0_fdone, o0_ehlen, o0_evlen;
  logic [7:0] o0_raw;
  logic [15:0] o0_fcnt;
  logic o3_vsync, o3_hsync, o3_den, o3_fdone, o3_ehlen, o3_evlen;
  logic [7:0] o3_raw;
  logic [15:0] o3_fcnt;

  bayer_mosaic_gen #(.source_h(SrcH), .source_v(SrcV), .BAYER_PATTERN(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
    .in_R(in_R), .in_G(in_G), .in_B(in_B), .err_clr(err_clr),
    .out_vsync(o0_vsync), .out_hsync(o0_hsync), .out_den(o0_den), .out_raw(o0_raw),
    .frame_done(o0_fdone), .frame_cnt(o0_fcnt), .err_hlen(o0_ehlen), .err_vlen(o0_evlen)
  );

  bayer_mosaic_gen #(.source_h(SrcH), .source_v(SrcV), .BAYER_PATTERN(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
    .in_R(in_R), .in_G(in_G), .in_B(in_B), .err_clr(err_clr),
    .out_vsync(o3_vsync), .out_hsync(o3_hsync), .out_den(o3_den), .out_raw(o3_raw),
    .frame_done(o3_fdone), .frame_cnt(o3_fcnt), .err_hlen(o3_ehlen), .err_vlen(o3_evlen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int due; logic [7:0] v;} pix_t;
  typedef struct {int due; int sig; logic [15:0] exp;} chk_t;
  pix_t q0[$];
  pix_t q3[$];
  chk_t pend[$];

  // Hand-derived from the CFA tables, indexed by {y[0], x[0]}.
  logic [7:0] rggb_tab[4] = '{8'h10, 8'h20, 8'h20, 8'h30};
  logic [7:0] bggr_tab[4] = '{8'h30, 8'h20, 8'h20, 8'h10};

  int len[8] = '{4, 4, 4, 4, 4, 4, 4, 4};
  bit live = 1'b1;
  logic exp_hlen = 1'b0, exp_vlen = 1'b0;
  logic [15:0] exp_fcnt = 16'd0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sig_val(input int s);
    case (s)
      0: return {15'd0, o0_ehlen};
      1: return {15'd0, o0_evlen};
      2: return {15'd0, o0_fdone};
      3: return {15'd0, o0_vsync};
      default: return o0_fcnt;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0: return "err_hlen";
      1: return "err_vlen";
      2: return "frame_done";
      3: return "out_vsync";
      default: return "frame_cnt";
    endcase
  endfunction

  task automatic sched(input int d, input int s, input logic [15:0] e);
    pend.push_back('{cyc + d, s, e});
  endtask

  // Pixel monitor for both phases.
  always @(negedge clk) begin
    pix_t e;
    if (o0_den) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL raw0_unexpected: got out_den=1 raw=%0h, expected no pixel (cycle %0d)",
                 o0_raw, cyc);
      end else begin
        e = q0.pop_front();
        check("raw0_value", {8'h00, o0_raw}, {8'h00, e.v});
        check("raw0_latency", 16'(cyc), 16'(e.due));
      end
    end else begin
      check("raw0_idle_zero", {8'h00, o0_raw}, 16'h0000);
    end
    if (o3_den) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL raw3_unexpected: got out_den=1 raw=%0h, expected no pixel (cycle %0d)",
                 o3_raw, cyc);
      end else begin
        e = q3.pop_front();
        check("raw3_value", {8'h00, o3_raw}, {8'h00, e.v});
        check("raw3_latency", 16'(cyc), 16'(e.due));
      end
    end
  end

  // Flag monitor: scheduled single-cycle checks.
  always @(negedge clk) begin
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        check(sig_name(pend[i].sig), sig_val(pend[i].sig), pend[i].exp);
        pend.delete(i);
      end
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic de);
    @(posedge clk);
    #1;
    in_vsync = vs;
    in_hsync = hs;
    in_den   = de;
    err_clr  = 1'b0;
    reset_n  = 1'b1;
  endtask

  task automatic run_frame(input int nl, input int tail_gap, input int rst_line,
                           input int clr_line);
    int idx;
    logic bad;
    bit merged;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int ln = 0; ln < nl; ln++) begin
      if (ln == rst_line) live = 1'b0;
      for (int px = 0; px < len[ln]; px++) begin
        drive(1'b1, 1'b1, 1'b1);
        if (ln == rst_line && px == 1) begin
          reset_n  = 1'b0;
          exp_fcnt = 16'd0;
          exp_hlen = 1'b0;
          exp_vlen = 1'b0;
        end
        if (live) begin
          idx = (ln % 2) * 2 + (px % 2);
          q0.push_back('{cyc + 2, rggb_tab[idx]});
          q3.push_back('{cyc + 2, bggr_tab[idx]});
        end
      end
      merged = (ln == nl - 1) && (tail_gap == 0);
      drive(merged ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (live && len[ln] != SrcH) begin
        if (ln == clr_line) err_clr = 1'b1;
        sched(1, 0, {15'd0, exp_hlen});
        sched(2, 0, 16'd1);
        exp_hlen = 1'b1;
      end
      if (!merged) drive(1'b1, 1'b0, 1'b0);
    end
    if (tail_gap != 0) drive(1'b0, 1'b0, 1'b0);
    if (live) begin
      bad = (nl != SrcV);
      sched(1, 2, 16'd0);
      sched(1, 1, {15'd0, exp_vlen});
      sched(1, 3, 16'd1);
      sched(1, 4, exp_fcnt);
      exp_vlen = exp_vlen | bad;
      exp_fcnt = exp_fcnt + 16'd1;
      sched(2, 2, 16'd1);
      sched(2, 1, {15'd0, exp_vlen});
      sched(2, 3, 16'd0);
      sched(2, 4, exp_fcnt);
      sched(2, 0, {15'd0, exp_hlen});
      sched(3, 2, 16'd0);
    end else begin
      sched(2, 2, 16'd0);
      sched(2, 4, exp_fcnt);
      live = 1'b1;
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr();
    drive(1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    sched(1, 0, 16'd0);
    sched(1, 1, 16'd0);
    exp_hlen = 1'b0;
    exp_vlen = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vsync", {15'd0, o0_vsync}, 16'd0);
    check("rst_out_hsync", {15'd0, o0_hsync}, 16'd0);
    check("rst_out_den", {15'd0, o0_den}, 16'd0);
    check("rst_out_raw", {8'd0, o0_raw}, 16'd0);
    check("rst_frame_done", {15'd0, o0_fdone}, 16'd0);
    check("rst_frame_cnt", o0_fcnt, 16'd0);
    check("rst_err_hlen", {15'd0, o0_ehlen}, 16'd0);
    check("rst_err_vlen", {15'd0, o0_evlen}, 16'd0);

    // Unsynced start: in_vsync already high, syncs pass but no pixels.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    sched(2, 3, 16'd1);
    repeat (3) drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 1'b0);

    run_frame(4, 1, -1, -1);             // clean frame
    run_frame(4, 0, -1, -1);             // last line ends with vsync
    len[2] = 3;
    run_frame(4, 1, -1, -1);             // short line
    len[2] = 4;
    pulse_clr();
    run_frame(4, 1, -1, -1);             // clean after clear
    run_frame(5, 1, -1, -1);             // tall frame
    pulse_clr();
    run_frame(4, 1, 1, -1);              // reset mid line 1
    run_frame(4, 1, -1, -1);             // first frame after resync
    len[1] = 3;
    len[2] = 3;
    run_frame(4, 1, -1, 2);              // clear coincident with a short line
    len[1] = 4;
    len[2] = 4;
    repeat (6) drive(1'b0, 1'b0, 1'b0);

    check("q0_drained", 16'(q0.size()), 16'd0);
    check("q3_drained", 16'(q3.size()), 16'd0);
    check("flag_checks_drained", 16'(pend.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
